ahb_apb_bridge_ctrl: RTL and testbench
======================================

AHB_APB_BRIDGE_CTRL -- requirements
Module: ahb_apb_bridge_ctrl

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset: clock Hclk, reset Hreset.
REQ-002 Hclk  input  1  bridge clock; all state updates on its rising edge.
REQ-003 Hreset  input  1  synchronous active-high reset.
REQ-004 HSEL  input  1  bridge slave select.
REQ-005 HTRANS  input  2  AHB transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-006 HREADY  input  1  AHB bus ready; qualifies the address phase.
REQ-007 HWRITE  input  1  1 = write, 0 = read.
REQ-008 HADDR  input  32  AHB address.
REQ-009 HWDATA  input  32  AHB write data, valid in the data phase.
REQ-010 HREADYOUT  output  1  bridge ready; 0 stalls the AHB data phase.
REQ-011 HRDATA  output  32  read data to AHB.
REQ-012 PSEL  output  1  APB select.
REQ-013 PENABLE  output  1  APB enable.
REQ-014 PWRITE  output  1  APB direction.
REQ-015 PADDR  output  32  APB address.
REQ-016 PWDATA  output  32  APB write data.
REQ-017 PRDATA  input  32  APB read data.
REQ-018 PREADY  input  1  APB ready; present only when BRIDGE_PREADY_EN is defined.

Function
REQ-019 Valid transfer SHALL be HSEL=1 & HREADY=1 & HTRANS[1]=1; IDLE/BUSY and unselected cycles SHALL be ignored.
REQ-020 FSM states SHALL be IDLE, WDATA, SETUP, ACCESS; outputs decoded from registered state and registers only.
REQ-021 IDLE: HREADYOUT=1, PSEL=0, PENABLE=0; on valid transfer latch HADDR->PADDR, HWRITE->PWRITE; next WDATA if write, else SETUP; otherwise stay.
REQ-022 WDATA: HREADYOUT=0, PSEL=0; latch HWDATA->PWDATA; next SETUP.
REQ-023 SETUP: PSEL=1, PENABLE=0, HREADYOUT=0; next ACCESS unconditionally.
REQ-024 ACCESS: PSEL=1, PENABLE=1, HREADYOUT=0; on completion (REQ-034/035) latch PRDATA->HRDATA if PWRITE=0, next IDLE.
REQ-025 Read latency: address phase at cycle N -> HREADYOUT=1 and HRDATA valid at cycle N+3 (no APB wait states).
REQ-026 Write latency: address phase at cycle N -> HREADYOUT=1 at cycle N+4 (no APB wait states).
REQ-027 PADDR, PWRITE, PWDATA SHALL stay stable from SETUP through end of ACCESS.
REQ-028 HRDATA SHALL hold its last value after writes and while idle.
REQ-029 A valid transfer sampled in IDLE on the completion cycle of the previous transfer SHALL start immediately (back-to-back, no bubble).
REQ-030 Inputs in WDATA/SETUP/ACCESS other than HWDATA (WDATA) and PRDATA/PREADY (ACCESS) SHALL be ignored; HBURST is not used; each beat is an independent APB transfer.

Reset
REQ-031 On Hreset=1 at a clock edge, state SHALL go to IDLE regardless of current state, including mid-SETUP/ACCESS.
REQ-032 Reset values: HREADYOUT=1, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, HRDATA=0.
REQ-033 A transfer interrupted by reset SHALL be dropped with no completion; first valid transfer after reset deasserts SHALL be sampled normally.

Configuration
REQ-034 Macro BRIDGE_PREADY_EN defined: PREADY port present; ACCESS SHALL persist while PREADY=0 and complete in the cycle PREADY=1.
REQ-035 BRIDGE_PREADY_EN undefined: PREADY port absent; ACCESS SHALL last exactly one cycle.

Verification
REQ-036 Read: NONSEQ HSEL=1 HWRITE=0 HADDR=0x0000_1004, PRDATA=0xCAFE_0001 -> SETUP cycle N+1, ACCESS N+2, HREADYOUT=1, HRDATA=0xCAFE_0001 at N+3.
REQ-037 Write: NONSEQ HWRITE=1 HADDR=0x0000_2000, HWDATA=0xDEAD_BEEF next cycle -> PSEL=1 PWRITE=1 PADDR=0x2000 PWDATA=0xDEAD_BEEF at N+2, PENABLE=1 at N+3, HREADYOUT=1 at N+4.
REQ-038 HTRANS=01 or HSEL=0 or HREADY=0 with valid address -> PSEL stays 0, HREADYOUT stays 1.
REQ-039 BRIDGE_PREADY_EN defined, read with PREADY low 3 cycles in ACCESS -> PENABLE=1 for 4 cycles, HRDATA latched only when PREADY=1.
REQ-040 Back-to-back write 0x10 then read 0x14 -> second SETUP starts the cycle after first return to IDLE; PADDR=0x14.
REQ-041 Hreset=1 during ACCESS -> next cycle PSEL=0, PENABLE=0, HREADYOUT=1, all registers at reset values.

Source files
------------

// File: rtl/ahb_apb_bridge_ctrl.sv
// AHB-to-APB bridge controller: one AHB beat becomes one APB SETUP/ACCESS transfer.
// Define BRIDGE_PREADY_EN to add the PREADY port and allow APB wait states.
module ahb_apb_bridge_ctrl (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        HSEL,
  input  logic [1:0]  HTRANS,
  input  logic        HREADY,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
`ifdef BRIDGE_PREADY_EN
  input  logic        PREADY,
`endif
  input  logic [31:0] PRDATA
);

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WDATA  = 2'd1,
    ST_SETUP  = 2'd2,
    ST_ACCESS = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic valid_c;
  logic access_done_c;
  logic hreadyout_nxt;
  logic psel_nxt;
  logic penable_nxt;

  assign valid_c = HSEL & HREADY & (HTRANS inside {HTRANS_NONSEQ, HTRANS_SEQ});

`ifdef BRIDGE_PREADY_EN
  assign access_done_c = PREADY;
`else
  assign access_done_c = 1'b1;
`endif

  // State register
  always_ff @(posedge Hclk) begin
    if (Hreset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (valid_c) state_nxt = HWRITE ? ST_WDATA : ST_SETUP;
      ST_WDATA:  state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: if (access_done_c) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Control outputs are pre-decoded from the next state so they leave a flop
  always_comb begin
    hreadyout_nxt = 1'b0;
    psel_nxt      = 1'b0;
    penable_nxt   = 1'b0;
    case (state_nxt)
      ST_IDLE:   hreadyout_nxt = 1'b1;
      ST_SETUP:  psel_nxt      = 1'b1;
      ST_ACCESS: begin
        psel_nxt    = 1'b1;
        penable_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      HREADYOUT <= 1'b1;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= 32'h0;
      PWDATA    <= 32'h0;
      HRDATA    <= 32'h0;
    end else begin
      HREADYOUT <= hreadyout_nxt;
      PSEL      <= psel_nxt;
      PENABLE   <= penable_nxt;
      if (state == ST_IDLE && valid_c) begin
        PADDR  <= HADDR;
        PWRITE <= HWRITE;
      end
      if (state == ST_WDATA) PWDATA <= HWDATA;
      if (state == ST_ACCESS && access_done_c && !PWRITE) HRDATA <= PRDATA;
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge_ctrl.sv
// Directed, table-driven bench for ahb_apb_bridge_ctrl; one vector per clock cycle.
// Honours BRIDGE_PREADY_EN for the PREADY port and the wait-state sequence.
module tb_ahb_apb_bridge_ctrl;

  logic        Hclk;
  logic        Hreset;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic        HWRITE;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;

  int n_tests;
  int n_fail;

  ahb_apb_bridge_ctrl dut (
    .Hclk      (Hclk),
    .Hreset    (Hreset),
    .HSEL      (HSEL),
    .HTRANS    (HTRANS),
    .HREADY    (HREADY),
    .HWRITE    (HWRITE),
    .HADDR     (HADDR),
    .HWDATA    (HWDATA),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
`ifdef BRIDGE_PREADY_EN
    .PREADY    (PREADY),
`endif
    .PRDATA    (PRDATA)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  typedef struct {
    logic        hsel;
    logic [1:0]  htrans;
    logic        hready;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] prdata;
    logic        e_rdy;
    logic        e_psel;
    logic        e_pen;
    logic        e_pw;
    logic [31:0] e_paddr;
    logic [31:0] e_pwdata;
    logic [31:0] e_hrdata;
  } vec_t;

  localparam int unsigned NVEC = 20;
  vec_t vecs [NVEC];

  task automatic drive(input logic hsel, input logic [1:0] htrans, input logic hready,
                       input logic hwrite, input logic [31:0] haddr,
                       input logic [31:0] hwdata, input logic [31:0] prdata);
    HSEL   = hsel;
    HTRANS = htrans;
    HREADY = hready;
    HWRITE = hwrite;
    HADDR  = haddr;
    HWDATA = hwdata;
    PRDATA = prdata;
  endtask

  task automatic step();
    @(posedge Hclk);
    #1;
  endtask

  task automatic check(input string name, input logic rdy, input logic psel, input logic pen,
                       input logic pw, input logic [31:0] paddr, input logic [31:0] pwdata,
                       input logic [31:0] hrdata);
    n_tests++;
    if (HREADYOUT !== rdy || PSEL !== psel || PENABLE !== pen || PWRITE !== pw ||
        PADDR !== paddr || PWDATA !== pwdata || HRDATA !== hrdata) begin
      n_fail++;
      $display("FAIL %s: got rdy=%b psel=%b pen=%b pw=%b paddr=%h pwdata=%h hrdata=%h; want rdy=%b psel=%b pen=%b pw=%b paddr=%h pwdata=%h hrdata=%h",
               name, HREADYOUT, PSEL, PENABLE, PWRITE, PADDR, PWDATA, HRDATA,
               rdy, psel, pen, pw, paddr, pwdata, hrdata);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // ignored cycles, read, write, back-to-back write->read, SEQ read left in ACCESS
    vecs[0]  = '{1'b0, 2'b00, 1'b1, 1'b0, 32'h0,      32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,        32'h0};
    vecs[1]  = '{1'b1, 2'b01, 1'b1, 1'b0, 32'h100,    32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,        32'h0};
    vecs[2]  = '{1'b0, 2'b10, 1'b1, 1'b0, 32'h100,    32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,        32'h0};
    vecs[3]  = '{1'b1, 2'b10, 1'b0, 1'b0, 32'h100,    32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,        32'h0};
    vecs[4]  = '{1'b1, 2'b10, 1'b1, 1'b0, 32'h1004,   32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h1004, 32'h0,        32'h0};
    vecs[5]  = '{1'b1, 2'b10, 1'b1, 1'b1, 32'hFFFF,   32'h0,        32'h11111111, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1004, 32'h0,        32'h0};
    vecs[6]  = '{1'b0, 2'b00, 1'b1, 1'b0, 32'h0,      32'h0,        32'hCAFE0001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1004, 32'h0,        32'hCAFE0001};
    vecs[7]  = '{1'b1, 2'b10, 1'b1, 1'b1, 32'h2000,   32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h2000, 32'h0,        32'hCAFE0001};
    vecs[8]  = '{1'b0, 2'b00, 1'b1, 1'b0, 32'h0,      32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h2000, 32'hDEADBEEF, 32'hCAFE0001};
    vecs[9]  = '{1'b0, 2'b00, 1'b1, 1'b0, 32'h0,      32'h0,        32'h55,       1'b0, 1'b1, 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 32'hCAFE0001};
    vecs[10] = '{1'b0, 2'b00, 1'b1, 1'b0, 32'h0,      32'h0,        32'h77,       1'b1, 1'b0, 1'b0, 1'b1, 32'h2000, 32'hDEADBEEF, 32'hCAFE0001};
    vecs[11] = '{1'b1, 2'b10, 1'b1, 1'b1, 32'h10,     32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h10,   32'hDEADBEEF, 32'hCAFE0001};
    vecs[12] = '{1'b0, 2'b00, 1'b1, 1'b0, 32'h0,      32'hA5A5A5A5, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h10,   32'hA5A5A5A5, 32'hCAFE0001};
    vecs[13] = '{1'b1, 2'b10, 1'b1, 1'b0, 32'h99,     32'h0,        32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h10,   32'hA5A5A5A5, 32'hCAFE0001};
    vecs[14] = '{1'b1, 2'b10, 1'b0, 1'b0, 32'h14,     32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 32'h10,   32'hA5A5A5A5, 32'hCAFE0001};
    vecs[15] = '{1'b1, 2'b10, 1'b1, 1'b0, 32'h14,     32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h14,   32'hA5A5A5A5, 32'hCAFE0001};
    vecs[16] = '{1'b0, 2'b00, 1'b1, 1'b0, 32'h0,      32'h0,        32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h14,   32'hA5A5A5A5, 32'hCAFE0001};
    vecs[17] = '{1'b0, 2'b00, 1'b1, 1'b0, 32'h0,      32'h0,        32'hBEEF0014, 1'b1, 1'b0, 1'b0, 1'b0, 32'h14,   32'hA5A5A5A5, 32'hBEEF0014};
    vecs[18] = '{1'b1, 2'b11, 1'b1, 1'b0, 32'h18,     32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h18,   32'hA5A5A5A5, 32'hBEEF0014};
    vecs[19] = '{1'b0, 2'b00, 1'b1, 1'b0, 32'h0,      32'h0,        32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 32'h18,   32'hA5A5A5A5, 32'hBEEF0014};

    PREADY = 1'b1;
    Hreset = 1'b1;
    drive(1'b1, 2'b10, 1'b1, 1'b1, 32'h1234, 32'h5678, 32'h9ABC);
    step();
    step();
    check("reset_values", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    Hreset = 1'b0;

    for (int i = 0; i < int'(NVEC); i++) begin
      drive(vecs[i].hsel, vecs[i].htrans, vecs[i].hready, vecs[i].hwrite,
            vecs[i].haddr, vecs[i].hwdata, vecs[i].prdata);
      step();
      check($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_psel, vecs[i].e_pen,
            vecs[i].e_pw, vecs[i].e_paddr, vecs[i].e_pwdata, vecs[i].e_hrdata);
    end

    // Reset while in ACCESS: transfer dropped, nothing latched
    Hreset = 1'b1;
    drive(1'b0, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'h12345678);
    step();
    check("reset_in_access", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    Hreset = 1'b0;
    drive(1'b1, 2'b10, 1'b1, 1'b1, 32'h40, 32'h0, 32'h0);
    step();
    check("post_reset_write_wdata", 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0);
    drive(1'b0, 2'b00, 1'b1, 1'b0, 32'h0, 32'h600D0040, 32'h0);
    step();
    check("post_reset_write_setup", 1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h600D0040, 32'h0);
    drive(1'b0, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    step();
    check("post_reset_write_access", 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h600D0040, 32'h0);
    step();
    check("post_reset_write_done", 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h600D0040, 32'h0);

`ifdef BRIDGE_PREADY_EN
    // Read stretched by three PREADY-low ACCESS cycles
    drive(1'b1, 2'b10, 1'b1, 1'b0, 32'h30, 32'h0, 32'h0);
    step();
    check("wait_setup", 1'b0, 1'b1, 1'b0, 1'b0, 32'h30, 32'h600D0040, 32'h0);
    PREADY = 1'b0;
    drive(1'b0, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 32'h9);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("wait_access%0d", k), 1'b0, 1'b1, 1'b1, 1'b0, 32'h30, 32'h600D0040, 32'h0);
    end
    PREADY = 1'b1;
    PRDATA = 32'hF00D0030;
    step();
    check("wait_done", 1'b1, 1'b0, 1'b0, 1'b0, 32'h30, 32'h600D0040, 32'hF00D0030);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
